// File: rtl/regfile_pkg.sv
// Shared register-file types and default widths used by the write-port sharing logic.
package regfile_pkg;
  localparam int unsigned RWIDTH_DEF = 6;
  localparam int unsigned DWIDTH_DEF = 32;

  typedef logic [RWIDTH_DEF-1:0] reg_addr_t;
  typedef logic [DWIDTH_DEF-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t wa;
    reg_data_t wd;
  } wr_req_t;
endpackage

// File: rtl/regfile_wr_arbiter_rr_picker.sv
// Combinational rotating-priority picker: one-hot grant to the first valid bit at or after ptr.
module rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        k = (32'(ptr) + i) % N;
        if (!any && valid[k]) begin
          grant[k] = 1'b1;
          idx      = PW'(k);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin sharing of the single register-file write port with a registered write stage.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned RWIDTH   = RWIDTH_DEF,
  parameter int unsigned DWIDTH   = DWIDTH_DEF,
  parameter int unsigned NREQ     = 2,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*RWIDTH-1:0] req_wa,
  input  logic [NREQ*DWIDTH-1:0] req_wd,
  output logic [NREQ-1:0]        req_ready,
  output logic [RWIDTH-1:0]      wa,
  output logic [DWIDTH-1:0]      wd,
  output logic                   we,
  output logic [IDW-1:0]         grant_id
);

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    win;
  logic              hs;
  logic [RWIDTH-1:0] sel_wa;
  logic [DWIDTH-1:0] sel_wd;

  // Reset gates the picker so no handshake can complete while rst is high.
  rr_picker #(
    .N  (NREQ),
    .PW (IDW)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .en    (!stall && !rst),
    .grant (req_ready),
    .idx   (win),
    .any   (hs)
  );

  always_comb begin
    sel_wa = '0;
    sel_wd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_wa = req_wa[i*RWIDTH +: RWIDTH];
        sel_wd = req_wd[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wa       <= '0;
      wd       <= '0;
      we       <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (hs) begin
      wa       <= sel_wa;
      wd       <= sel_wd;
      grant_id <= win;
      we       <= !(ZERO_REG && (sel_wa == '0));
      rr_ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else begin
      we <= 1'b0;
    end
  end

endmodule
